biu_bus_initiator: RTL

Bus initiator for the 8086-style minimum-mode local bus. It converts single-beat read/write requests from the CPU core into T1–T4 bus cycles on ALE/IOM/RD/WR/Address/Data, inserting wait states while READY is low. It returns read data or a timeout error to the core and yields the bus to an external master via HOLD/HLDA. It is the initiator counterpart of the memory/IO responder blocks on the same bus.

---
 rtl/biu_bus_pkg.sv | 21 ++
 rtl/biu_wait_timer.sv | 27 ++
 rtl/biu_bus_initiator.sv | 135 +++++++++++++
 3 files changed

// File: rtl/biu_bus_pkg.sv
// Shared types and constants for the 8086-style minimum-mode bus initiator.
package biu_bus_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 8;

    // RD, WR and DEN are active low, so their idle level is high.
    localparam logic STROBE_OFF = 1'b1;
    localparam logic STROBE_ON  = 1'b0;

    typedef enum logic [6:0] {
        IDLE   = 7'b000_0001,
        T1     = 7'b000_0010,
        T2     = 7'b000_0100,
        T3     = 7'b000_1000,
        TW     = 7'b001_0000,
        T4     = 7'b010_0000,
        HOLDST = 7'b100_0000
    } BusState_t;

endpackage

// File: rtl/biu_wait_timer.sv
// Saturating count of consecutive wait states; flags a timeout once MAX_WAIT is reached.
module biu_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear_i,
    input  logic enable_i,
    output logic timeout_o
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count_q;

    assign timeout_o = (count_q == CNT_W'(MAX_WAIT));

    // Holding at MAX_WAIT keeps the timeout asserted instead of wrapping to zero.
    always_ff @(posedge CLK) begin
        if (RESET || clear_i) begin
            count_q <= '0;
        end else if (enable_i && !timeout_o) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/biu_bus_initiator.sv
// Converts single-beat core requests into T1-T4 local-bus cycles with wait states and HOLD/HLDA.
module biu_bus_initiator
    import biu_bus_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic              req_io,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] Address,
    inout  wire  [DATA_W-1:0] Data,
    output logic              ALE,
    output logic              IOM,
    output logic              RD,
    output logic              WR,
    output logic              DEN,
    output logic              DTR,
    input  logic              READY,
    input  logic              HOLD,
    output logic              HLDA
);

    BusState_t         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic              io_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic handshake;
    logic waiting;
    logic timeout;
    logic holdSt;
    logic inCycle;
    logic strobeOn;
    logic driveData;

    assign req_ready = (state_q == IDLE) && !RESET && !HOLD;
    assign handshake = req_valid && req_ready;
    assign waiting   = (state_q inside {T3, TW}) && !READY;

    biu_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .CLK       (CLK),
        .RESET     (RESET),
        .clear_i   (state_q == T4),
        .enable_i  (waiting),
        .timeout_o (timeout)
    );

    // HOLD is only looked at in IDLE, so a cycle in flight always runs to T4 first.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            io_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (HOLD) begin
                        state_q <= HOLDST;
                    end else if (handshake) begin
                        addr_q  <= req_addr;
                        write_q <= req_write;
                        io_q    <= req_io;
                        wdata_q <= req_wdata;
                        state_q <= T1;
                    end
                end
                T1: state_q <= T2;
                T2: state_q <= T3;
                T3, TW: begin
                    if (READY) begin
                        if (!write_q) begin
                            rdata_q <= Data;
                        end
                        state_q <= T4;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        state_q <= T4;
                    end else begin
                        state_q <= TW;
                    end
                end
                T4: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                HOLDST: begin
                    if (!HOLD) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign holdSt    = (state_q == HOLDST);
    assign inCycle   = state_q inside {T1, T2, T3, TW, T4};
    assign strobeOn  = state_q inside {T2, T3, TW};
    // Write data stays on the bus through T4 to give the responder hold time.
    assign driveData = write_q && (state_q inside {T2, T3, TW, T4});

    assign ALE     = (state_q == T1);
    assign HLDA    = holdSt;
    assign Address = holdSt ? {ADDR_W{1'bz}} : addr_q;
    assign IOM     = holdSt ? 1'bz : io_q;
    assign RD      = holdSt ? 1'bz : ((strobeOn && !write_q) ? STROBE_ON : STROBE_OFF);
    assign WR      = holdSt ? 1'bz : ((strobeOn && write_q) ? STROBE_ON : STROBE_OFF);
    assign DEN     = holdSt ? 1'bz : (strobeOn ? STROBE_ON : STROBE_OFF);
    assign DTR     = holdSt ? 1'bz : (inCycle && write_q);
    assign Data    = driveData ? wdata_q : {DATA_W{1'bz}};

    assign rsp_valid = (state_q == T4);
    assign rsp_err   = (state_q == T4) && err_q;
    assign rsp_rdata = rdata_q;

endmodule
